div: RTL

- Sequential unsigned restoring divider; the inverse of the team's shift-add `mult` block.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing a WIDTH-bit quotient and remainder, one quotient bit per clock.
- Uses the same ctrl_enable/ctrl_done level handshake as `mult`, so the two can share a controller in the arithmetic datapath.

---
 rtl/div.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div.sv
// div: sequential unsigned restoring divider, one quotient bit per clock.
// Dividend is 2*WIDTH bits; divisor, quotient and remainder are WIDTH bits.
// Ports:
//   clk, rst (async, active low)
//   data_dividend, data_divisor : operands, sampled at the capture edge
//   ctrl_enable : level request, held until ctrl_done
//   data_quotient, data_remainder : registered result
//   ctrl_done : result valid
//   ctrl_overflow : quotient too wide, or divide by zero
module div #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*WIDTH-1:0]   data_dividend,
   input  logic [WIDTH-1:0]     data_divisor,
   input  logic                 ctrl_enable,
   output logic [WIDTH-1:0]     data_quotient,
   output logic [WIDTH-1:0]     data_remainder,
   output logic                 ctrl_done,
   output logic                 ctrl_overflow
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state, state_n;
   // R < divisor at every iteration start, so W bits hold it
   logic [WIDTH-1:0]  r, r_n;
   logic [WIDTH-1:0]  q, q_n;
   logic [WIDTH-1:0]  dvs, dvs_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [WIDTH-1:0]  quot_n, rem_n;
   logic              done_n, ovf_n;

   logic [WIDTH-1:0]  hi;
   logic [WIDTH:0]    r_sh;
   logic [WIDTH-1:0]  r_sub;
   logic              fits;
   logic [WIDTH-1:0]  r_new, q_new;
   logic              last;

   assign hi    = data_dividend[2*WIDTH-1:WIDTH];
   assign r_sh  = {r, q[WIDTH-1]};
   assign fits  = r_sh >= {1'b0, dvs};
   // result is < divisor, so the W-bit wrap is exact
   assign r_sub = r_sh[WIDTH-1:0] - dvs;
   assign r_new = fits ? r_sub : r_sh[WIDTH-1:0];
   assign q_new = {q[WIDTH-2:0], fits};
   assign last  = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         r              <= '0;
         q              <= '0;
         dvs            <= '0;
         cnt            <= '0;
         data_quotient  <= '0;
         data_remainder <= '0;
         ctrl_done      <= 1'b0;
         ctrl_overflow  <= 1'b0;
      end else begin
         state          <= state_n;
         r              <= r_n;
         q              <= q_n;
         dvs            <= dvs_n;
         cnt            <= cnt_n;
         data_quotient  <= quot_n;
         data_remainder <= rem_n;
         ctrl_done      <= done_n;
         ctrl_overflow  <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      r_n     = r;
      q_n     = q;
      dvs_n   = dvs;
      cnt_n   = cnt;
      quot_n  = data_quotient;
      rem_n   = data_remainder;
      done_n  = ctrl_done;
      ovf_n   = ctrl_overflow;
      unique case (state)
         IDLE: begin
            if (ctrl_enable) begin
               if (hi >= data_divisor) begin
                  // covers divisor == 0 as well
                  state_n = DONE;
                  quot_n  = '1;
                  rem_n   = '0;
                  ovf_n   = 1'b1;
                  done_n  = 1'b1;
               end else begin
                  state_n = RUN;
                  r_n     = hi;
                  q_n     = data_dividend[WIDTH-1:0];
                  dvs_n   = data_divisor;
                  cnt_n   = '0;
               end
            end
         end
         RUN: begin
            if (!ctrl_enable) begin
               state_n = IDLE;
            end else begin
               r_n   = r_new;
               q_n   = q_new;
               cnt_n = cnt + 1'b1;
               if (last) begin
                  state_n = DONE;
                  quot_n  = q_new;
                  rem_n   = r_new;
                  ovf_n   = 1'b0;
                  done_n  = 1'b1;
               end
            end
         end
         DONE: begin
            if (!ctrl_enable) begin
               state_n = IDLE;
               done_n  = 1'b0;
               ovf_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
